// File: rtl/multi_prescale_counter.sv
// Multi-channel event counter.
// Each channel has its own runtime prescaler divisor, terminal limit and wrap/saturate mode.
module multi_prescale_counter #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 32,
  parameter int PRE_WIDTH = 8,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [N_CH-1:0]       En,
  input  logic [N_CH-1:0]       Clr,
  input  logic                  Ld_we,
  input  logic [CH_W-1:0]       Ld_ch,
  input  logic [PRE_WIDTH-1:0]  Ld_div,
  input  logic [WIDTH-1:0]      Ld_limit,
  input  logic                  Ld_mode,
  output logic [N_CH*WIDTH-1:0] Count,
  output logic [N_CH-1:0]       Tc
);

  logic [WIDTH-1:0]     cnt  [N_CH];
  logic [PRE_WIDTH-1:0] pre  [N_CH];
  logic [PRE_WIDTH-1:0] div  [N_CH];
  logic [WIDTH-1:0]     lim  [N_CH];
  logic                 mode [N_CH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt[i]  <= '0;
        pre[i]  <= '0;
        div[i]  <= '0;
        lim[i]  <= '1;
        mode[i] <= 1'b0;
      end
      Tc <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        Tc[i] <= 1'b0;
        if (Clr[i]) begin
          cnt[i] <= '0;
          pre[i] <= '0;
        end else if (En[i]) begin
          if (pre[i] == div[i]) begin
            pre[i] <= '0;
            if (!mode[i]) begin
              if (cnt[i] >= lim[i]) begin
                cnt[i] <= '0;
                Tc[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + WIDTH'(1);
              end
            end else if (cnt[i] < lim[i]) begin
              cnt[i] <= cnt[i] + WIDTH'(1);
              Tc[i]  <= ((cnt[i] + WIDTH'(1)) == lim[i]);
            end
          end else begin
            pre[i] <= pre[i] + PRE_WIDTH'(1);
          end
        end
        // Placed last so a load restarts the prescaler even when a step or clear hits the same edge.
        if (Ld_we && (Ld_ch == CH_W'(i))) begin
          div[i]  <= Ld_div;
          lim[i]  <= Ld_limit;
          mode[i] <= Ld_mode;
          pre[i]  <= '0;
        end
      end
    end
  end

  always_comb begin
    Count = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      Count[i*WIDTH +: WIDTH] = cnt[i];
    end
  end

endmodule

// File: tb/tb_multi_prescale_counter.sv
// Self-checking bench for multi_prescale_counter.
// Each scenario task drives stimulus and compares against a behavioural model of the channel rules.
module tb_multi_prescale_counter;
  localparam int N_CH = 4;
  localparam int W    = 32;
  localparam int PW   = 8;

  logic              Clk;
  logic              Reset;
  logic [N_CH-1:0]   En;
  logic [N_CH-1:0]   Clr;
  logic              Ld_we;
  logic [1:0]        Ld_ch;
  logic [PW-1:0]     Ld_div;
  logic [W-1:0]      Ld_limit;
  logic              Ld_mode;
  logic [N_CH*W-1:0] Count;
  logic [N_CH-1:0]   Tc;

  int checks   = 0;
  int failures = 0;

  // Model: remaining enabled cycles before the next step, plus the channel rules on count/Tc.
  logic [W-1:0]  m_cnt  [N_CH];
  int            m_rem  [N_CH];
  int            m_d    [N_CH];
  logic [W-1:0]  m_l    [N_CH];
  bit            m_mode [N_CH];
  logic [N_CH-1:0] m_tc;

  multi_prescale_counter #(.N_CH(N_CH), .WIDTH(W), .PRE_WIDTH(PW)) u_dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Clr(Clr), .Ld_we(Ld_we), .Ld_ch(Ld_ch),
    .Ld_div(Ld_div), .Ld_limit(Ld_limit), .Ld_mode(Ld_mode), .Count(Count), .Tc(Tc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_cnt[ch] = '0; m_rem[ch] = 0; m_d[ch] = 0; m_l[ch] = '1; m_mode[ch] = 1'b0;
    end
    m_tc = '0;
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] tc_n;
    tc_n = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (En[ch] && !Clr[ch]) begin
        if (m_rem[ch] == 0) begin
          m_rem[ch] = m_d[ch];
          if (!m_mode[ch]) begin
            if (m_cnt[ch] >= m_l[ch]) begin m_cnt[ch] = '0; tc_n[ch] = 1'b1; end
            else m_cnt[ch] = m_cnt[ch] + 1;
          end else if (m_cnt[ch] < m_l[ch]) begin
            m_cnt[ch] = m_cnt[ch] + 1;
            tc_n[ch] = (m_cnt[ch] == m_l[ch]);
          end
        end else begin
          m_rem[ch] = m_rem[ch] - 1;
        end
      end
      if (Clr[ch]) begin m_cnt[ch] = '0; m_rem[ch] = m_d[ch]; end
      if (Ld_we && int'(Ld_ch) == ch) begin
        m_d[ch] = int'(Ld_div); m_l[ch] = Ld_limit; m_mode[ch] = Ld_mode; m_rem[ch] = int'(Ld_div);
      end
    end
    m_tc = tc_n;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic load(input int ch, input int d, input logic [W-1:0] l, input bit md);
    Ld_we = 1'b1; Ld_ch = 2'(ch); Ld_div = PW'(d); Ld_limit = l; Ld_mode = md;
    tick();
    Ld_we = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; En = '0; Clr = '0; Ld_we = 1'b0; Ld_ch = '0; Ld_div = '0; Ld_limit = '0; Ld_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int ch = 0; ch < N_CH; ch++) begin
      checks++;
      if (Count[ch*W +: W] !== '0) begin
        failures++; $display("FAIL reset_count ch%0d got=%0d exp=0", ch, Count[ch*W +: W]);
      end
    end
    checks++;
    if (Tc !== '0) begin failures++; $display("FAIL reset_tc got=%b exp=0000", Tc); end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_free_run();
    En[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (Count[0 +: W] !== W'(t)) begin
        failures++; $display("FAIL free_run ch0 step%0d got=%0d exp=%0d", t, Count[0 +: W], t);
      end
      checks++;
      if (Count[N_CH*W-1:W] !== '0 || Tc !== '0) begin
        failures++; $display("FAIL free_run_others step%0d got=%h tc=%b exp=0", t, Count[N_CH*W-1:W], Tc);
      end
    end
  endtask

  task automatic test_clear();
    repeat (4) tick();
    checks++;
    if (Count[0 +: W] !== 32'd7) begin failures++; $display("FAIL clear_pre got=%0d exp=7", Count[0 +: W]); end
    Clr[0] = 1'b1;
    tick();
    Clr[0] = 1'b0;
    checks++;
    if (Count[0 +: W] !== '0 || Tc[0] !== 1'b0) begin
      failures++; $display("FAIL clear_wins got=%0d tc=%b exp=0 tc=0", Count[0 +: W], Tc[0]);
    end
    for (int t = 1; t <= 2; t++) begin
      tick();
      checks++;
      if (Count[0 +: W] !== W'(t)) begin
        failures++; $display("FAIL clear_resume got=%0d exp=%0d", Count[0 +: W], t);
      end
    end
    En[0] = 1'b0;
  endtask

  task automatic test_div_wrap();
    int pulses;
    pulses = 0;
    load(1, 3, 32'd2, 1'b0);
    En[1] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (Tc[1]) pulses++;
      checks++;
      if (Count[W +: W] !== W'((t / 4) % 3) || Tc[1] !== (t % 12 == 0)) begin
        failures++;
        $display("FAIL div_wrap t=%0d got=%0d tc=%b exp=%0d tc=%b", t, Count[W +: W], Tc[1], (t / 4) % 3, (t % 12 == 0));
      end
    end
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL div_wrap_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_freeze();
    Clr[1] = 1'b1;
    tick();
    Clr[1] = 1'b0;
    repeat (2) tick();
    En[1] = 1'b0;
    repeat (5) tick();
    checks++;
    if (Count[W +: W] !== '0) begin failures++; $display("FAIL freeze_hold got=%0d exp=0", Count[W +: W]); end
    En[1] = 1'b1;
    tick();
    checks++;
    if (Count[W +: W] !== '0) begin failures++; $display("FAIL freeze_remaining got=%0d exp=0", Count[W +: W]); end
    tick();
    checks++;
    if (Count[W +: W] !== 32'd1) begin failures++; $display("FAIL freeze_step got=%0d exp=1", Count[W +: W]); end
    En[1] = 1'b0;
  endtask

  task automatic test_saturate();
    int pulses;
    pulses = 0;
    load(2, 0, 32'd5, 1'b1);
    En[2] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (Tc[2]) pulses++;
      checks++;
      if (Count[2*W +: W] !== W'((t < 5) ? t : 5) || Tc[2] !== (t == 5)) begin
        failures++;
        $display("FAIL saturate t=%0d got=%0d tc=%b exp=%0d tc=%b", t, Count[2*W +: W], Tc[2], (t < 5) ? t : 5, (t == 5));
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL saturate_pulses got=%0d exp=1", pulses); end
    En[2] = 1'b0;
  endtask

  task automatic test_lower_limit();
    En[3] = 1'b1;
    repeat (10) tick();
    En[3] = 1'b0;
    checks++;
    if (Count[3*W +: W] !== 32'd10) begin failures++; $display("FAIL lower_pre got=%0d exp=10", Count[3*W +: W]); end
    load(3, 0, 32'd4, 1'b0);
    checks++;
    if (Count[3*W +: W] !== 32'd10) begin failures++; $display("FAIL load_keeps_count got=%0d exp=10", Count[3*W +: W]); end
    En[3] = 1'b1;
    tick();
    checks++;
    if (Count[3*W +: W] !== '0 || Tc[3] !== 1'b1) begin
      failures++; $display("FAIL lower_wrap got=%0d tc=%b exp=0 tc=1", Count[3*W +: W], Tc[3]);
    end
    tick();
    checks++;
    if (Count[3*W +: W] !== 32'd1 || Tc[3] !== 1'b0) begin
      failures++; $display("FAIL lower_next got=%0d tc=%b exp=1 tc=0", Count[3*W +: W], Tc[3]);
    end
    En[3] = 1'b0;
  endtask

  task automatic test_zero_limit();
    load(0, 0, 32'd0, 1'b0);
    En[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (Count[0 +: W] !== '0 || Tc[0] !== 1'b1) begin
        failures++; $display("FAIL zero_limit t=%0d got=%0d tc=%b exp=0 tc=1", t, Count[0 +: W], Tc[0]);
      end
    end
    En[0] = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      En    = N_CH'($urandom);
      Clr   = '0;
      for (int ch = 0; ch < N_CH; ch++) Clr[ch] = ($urandom_range(0, 15) == 0);
      Ld_we = ($urandom_range(0, 7) == 0);
      Ld_ch = 2'($urandom_range(0, N_CH - 1));
      Ld_div = PW'($urandom_range(0, 3));
      Ld_limit = W'($urandom_range(0, 9));
      Ld_mode = 1'($urandom);
      tick();
      for (int ch = 0; ch < N_CH; ch++) begin
        checks++;
        if (Count[ch*W +: W] !== m_cnt[ch] || Tc[ch] !== m_tc[ch]) begin
          failures++;
          $display("FAIL random n=%0d ch%0d got=%0d tc=%b exp=%0d tc=%b", n, ch, Count[ch*W +: W], Tc[ch], m_cnt[ch], m_tc[ch]);
        end
      end
    end
    Ld_we = 1'b0; Clr = '0;
  endtask

  task automatic test_async_reset();
    load(1, 3, 32'd2, 1'b1);
    En = '1;
    repeat (3) tick();
    #2 Reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (Count !== '0 || Tc !== '0) begin
      failures++; $display("FAIL async_reset got=%h tc=%b exp=0", Count, Tc);
    end
    @(negedge Clk);
    Reset = 1'b1;
    En = 4'b0010;
    tick();
    checks++;
    if (Count[W +: W] !== 32'd1 || Count[0 +: W] !== '0) begin
      failures++; $display("FAIL reset_config got=%0d ch0=%0d exp=1 ch0=0", Count[W +: W], Count[0 +: W]);
    end
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if (Count[W +: W] !== m_cnt[1] || Count[W +: W] !== 32'd5) begin
      failures++; $display("FAIL reset_mode got=%0d exp=5", Count[W +: W]);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_clear();
    test_div_wrap();
    test_freeze();
    test_saturate();
    test_lower_limit();
    test_zero_limit();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
